// File: rtl/ide_multi_ctrl.sv
// ide_multi_ctrl
//   Zorro II IDE interface: drive chip-select decode, boot ROM enable and
//   banking, a two-entry nibble-wide control register file and the IDE
//   IOR/IOW strobe generator with programmable PIO timing.
//
// Optional build macro:
//   IDE_IORDY_EN - adds the iordy input. The strobe is stretched while the
//                  drive holds IORDY low, bounded by the counter range.
//
// Ports:
//   clk, reset_n         bus clock, asynchronous active-low reset
//   addr[23:12]          Zorro address bits
//   din[3:0]             write data nibble for the control registers
//   rw                   1 = read cycle
//   as_n, ds_n           address / data strobes (ds_n high aborts a strobe)
//   ide_access           board IDE space decoded by the autoconfig logic
//   ide_enable           allows the first write to switch the IDE space live
//   z2_state             Zorro bus state, register cycles act in Z2_DATA
//   iordy                (IDE_IORDY_EN only) drive ready, active high
//   dout[3:0]            register read data
//   ide_enabled          IDE space is live
//   idecs1_n, idecs2_n   per-channel chip selects
//   ior_n, iow_n         IDE read / write strobes
//   rom_bank             flash bank select
//   ide_romen            flash enable, active low
//   idereg_access        control register space addressed
//   dtack                register cycle acknowledge
//   otherram_en          control bit REG0[1]
//   enable_maprom        control bit REG0[0]
module ide_multi_ctrl #(
  parameter int         CHANNELS  = 1,
  parameter int         BANK_BITS = 2,
  parameter int         CNT_W     = 3,
  parameter int         T_SETUP   = 5,
  parameter int         T_WRITE   = 5,
  parameter logic [1:0] Z2_DATA   = 2'd3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [23:12]         addr,
  input  logic [3:0]           din,
  input  logic                 rw,
  input  logic                 as_n,
  input  logic                 ds_n,
  input  logic                 ide_access,
  input  logic                 ide_enable,
  input  logic [1:0]           z2_state,
`ifdef IDE_IORDY_EN
  input  logic                 iordy,
`endif
  output logic [3:0]           dout,
  output logic                 ide_enabled,
  output logic [CHANNELS-1:0]  idecs1_n,
  output logic [CHANNELS-1:0]  idecs2_n,
  output logic                 ior_n,
  output logic                 iow_n,
  output logic [BANK_BITS-1:0] rom_bank,
  output logic                 ide_romen,
  output logic                 idereg_access,
  output logic                 dtack,
  output logic                 otherram_en,
  output logic                 enable_maprom
);

  localparam int CNT_MAX_I = (1 << CNT_W) - 1;
  localparam int SETUP_LIM = (T_SETUP > CNT_MAX_I) ? CNT_MAX_I : T_SETUP;
  localparam int WRITE_LIM = (T_WRITE > CNT_MAX_I) ? CNT_MAX_I : T_WRITE;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_CNT = SETUP_LIM[CNT_W-1:0];
  localparam logic [CNT_W-1:0] WRITE_CNT = WRITE_LIM[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 ior_nxt, iow_nxt;
  logic [BANK_BITS-1:0] bank;
  logic [BANK_BITS-1:0] rom_sel;
  logic [1:0]           chan_en;
  logic                 ch, drive, cs_hit, reg_start;
  logic [3:0]           reg0_val, reg1_val;
  logic                 unused_addr;

  assign unused_addr = ^{addr[23:17], addr[14]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // The IDE space stays dead until the first write with ide_enable set;
  // before that the whole board window maps to the boot ROM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ide_enabled <= 1'b0;
    else if (ide_enable && !rw && ide_access)
      ide_enabled <= 1'b1;
  end

  // Drive window decode: addr[16:15]==00 is the task file area, addr[14]
  // picks the channel on dual-channel boards, addr[13:12] picks CS1/CS2.
  assign ch    = (CHANNELS == 2) ? addr[14] : 1'b0;
  assign drive = ide_access && ide_enabled && (addr[16:15] == 2'b00) && chan_en[ch];

  always_comb begin
    idecs1_n = '1;
    idecs2_n = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (drive && (ch == 1'(c))) begin
        idecs1_n[c] = (addr[13:12] != 2'b01);
        idecs2_n[c] = (addr[13:12] != 2'b10);
      end
    end
  end

  assign cs_hit = !(&idecs1_n) || !(&idecs2_n);

  // ROM is visible over the whole window before enable, afterwards only in
  // the upper half. Before enable addr[16] doubles as the bank bit so the
  // boot code can reach both halves of the flash.
  assign ide_romen = !(ide_access && (!ide_enabled || addr[16]));

  always_comb begin
    rom_sel    = '0;
    rom_sel[0] = addr[16];
    rom_bank   = ide_enabled ? bank : rom_sel;
  end

  assign idereg_access = ide_access && ide_enabled && (addr[16:15] == 2'b01);
  assign reg0_val      = {2'(bank), otherram_en, enable_maprom};
  assign reg1_val      = {2'b00, (CHANNELS == 2) ? chan_en[1] : 1'b0, chan_en[0]};
  assign reg_start     = idereg_access && !as_n && (z2_state == Z2_DATA) && !dtack;

  // Control register cycles: one access per bus cycle. dtack latches on the
  // first data-phase edge and blocks further updates until AS is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank          <= '0;
      otherram_en   <= 1'b0;
      enable_maprom <= 1'b0;
      chan_en       <= 2'b11;
      dtack         <= 1'b0;
      dout          <= 4'h0;
    end else if (dtack) begin
      if (as_n)
        dtack <= 1'b0;
    end else if (reg_start) begin
      dtack <= 1'b1;
      if (rw) begin
        dout <= addr[12] ? reg1_val : reg0_val;
      end else if (!addr[12]) begin
        bank          <= BANK_BITS'(din[3:2]);
        otherram_en   <= din[1];
        enable_maprom <= din[0];
      end else begin
        chan_en[0] <= din[0];
        if (CHANNELS == 2)
          chan_en[1] <= din[1];
      end
    end
  end

`ifdef IDE_IORDY_EN
  logic             iordy_meta, iordy_s;
  logic [CNT_W-1:0] ext_cnt, ext_nxt;

  // Two-flop synchroniser for the drive's IORDY line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iordy_meta <= 1'b0;
      iordy_s    <= 1'b0;
    end else begin
      iordy_meta <= iordy;
      iordy_s    <= iordy_meta;
    end
  end
`endif

  // Strobe state register. A rising ds_n ends the bus cycle at once, so it
  // clears the sequencer asynchronously just like reset.
  always_ff @(posedge clk or negedge reset_n or posedge ds_n) begin
    if (!reset_n || ds_n) begin
      state <= IDLE;
      cnt   <= '0;
      ior_n <= 1'b1;
      iow_n <= 1'b1;
`ifdef IDE_IORDY_EN
      ext_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ior_n <= ior_nxt;
      iow_n <= iow_nxt;
`ifdef IDE_IORDY_EN
      ext_cnt <= ext_nxt;
`endif
    end
  end

  // Strobe sequencing. Reads wait T_SETUP edges of address setup before IOR
  // falls and keep it low for the rest of the cycle. Writes drop IOW on the
  // first edge, keep it low for T_WRITE edges, then park in HOLD with IOW
  // high so the data stays valid until DS goes away. With IORDY the low
  // phase runs on in ACTIVE while the drive is not ready; reads are then
  // paced by the drive rather than held for the whole bus cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ior_nxt   = ior_n;
    iow_nxt   = iow_n;
`ifdef IDE_IORDY_EN
    ext_nxt   = ext_cnt;
`endif
    case (state)
      IDLE: begin
        if (!ds_n && !as_n && cs_hit) begin
          cnt_nxt = CNT_ONE;
          if (rw) begin
            if (CNT_ONE >= SETUP_CNT) begin
              state_nxt = ACTIVE;
              ior_nxt   = 1'b0;
            end else begin
              state_nxt = SETUP;
            end
          end else begin
            state_nxt = SETUP;
            iow_nxt   = 1'b0;
          end
        end
      end
      SETUP: begin
        if (rw) begin
          cnt_nxt = sat_inc(cnt);
          if (cnt_nxt >= SETUP_CNT) begin
            state_nxt = ACTIVE;
            ior_nxt   = 1'b0;
          end
        end else if (cnt >= WRITE_CNT) begin
`ifdef IDE_IORDY_EN
          if (iordy_s) begin
            state_nxt = HOLD;
            iow_nxt   = 1'b1;
          end else begin
            state_nxt = ACTIVE;
            ext_nxt   = CNT_ONE;
          end
`else
          state_nxt = HOLD;
          iow_nxt   = 1'b1;
`endif
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      ACTIVE: begin
`ifdef IDE_IORDY_EN
        if (iordy_s || (ext_cnt == CNT_MAX)) begin
          state_nxt = HOLD;
          ior_nxt   = 1'b1;
          iow_nxt   = 1'b1;
        end else begin
          ext_nxt = sat_inc(ext_cnt);
        end
`endif
      end
      HOLD: begin
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ide_multi_ctrl.sv
// tb_ide_multi_ctrl
//   Self-checking bench for ide_multi_ctrl (dual channel, 2 bank bits).
//   A behavioural model of the register file and address map predicts every
//   output; strobe timing is measured in clock edges from DS low.
module tb_ide_multi_ctrl;

  localparam int         CHANNELS  = 2;
  localparam int         BANK_BITS = 2;
  localparam int         T_SETUP   = 5;
  localparam int         T_WRITE   = 5;
  localparam logic [1:0] Z2_DATA   = 2'd3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [23:12]  addr;
  logic [3:0]    din;
  logic          rw, as_n, ds_n, ide_access, ide_enable;
  logic [1:0]    z2_state;
  logic [3:0]    dout;
  logic          ide_enabled;
  logic [1:0]    idecs1_n, idecs2_n;
  logic          ior_n, iow_n;
  logic [1:0]    rom_bank;
  logic          ide_romen, idereg_access, dtack, otherram_en, enable_maprom;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_enabled;
  logic [1:0] m_bank;
  logic       m_other, m_map;
  logic [1:0] m_chan;

  always #5 clk = ~clk;

  ide_multi_ctrl #(
    .CHANNELS (CHANNELS),
    .BANK_BITS(BANK_BITS),
    .T_SETUP  (T_SETUP),
    .T_WRITE  (T_WRITE),
    .Z2_DATA  (Z2_DATA)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr         (addr),
    .din          (din),
    .rw           (rw),
    .as_n         (as_n),
    .ds_n         (ds_n),
    .ide_access   (ide_access),
    .ide_enable   (ide_enable),
    .z2_state     (z2_state),
`ifdef IDE_IORDY_EN
    .iordy        (1'b1),
`endif
    .dout         (dout),
    .ide_enabled  (ide_enabled),
    .idecs1_n     (idecs1_n),
    .idecs2_n     (idecs2_n),
    .ior_n        (ior_n),
    .iow_n        (iow_n),
    .rom_bank     (rom_bank),
    .ide_romen    (ide_romen),
    .idereg_access(idereg_access),
    .dtack        (dtack),
    .otherram_en  (otherram_en),
    .enable_maprom(enable_maprom)
  );

  function automatic logic [23:12] mk_addr(input logic a16, input logic a15,
                                           input logic a14, input logic [1:0] a1312);
    return {7'b0, a16, a15, a14, a1312};
  endfunction

  // Address map model: what the board should present for address a.
  task automatic model_decode(input logic [23:12] a, input logic acc,
                              output logic [1:0] cs1, output logic [1:0] cs2,
                              output logic romen, output logic [1:0] bank,
                              output logic ra);
    logic in_ide;
    in_ide = acc && m_enabled && (a[16:15] == 2'b00) && m_chan[a[14]];
    cs1 = 2'b11;
    cs2 = 2'b11;
    if (in_ide && a[13:12] == 2'b01) cs1[a[14]] = 1'b0;
    if (in_ide && a[13:12] == 2'b10) cs2[a[14]] = 1'b0;
    romen = !(acc && (!m_enabled || a[16]));
    bank  = m_enabled ? m_bank : {1'b0, a[16]};
    ra    = acc && m_enabled && (a[16:15] == 2'b01);
  endtask

  task automatic model_reset();
    m_enabled = 1'b0;
    m_bank    = 2'b00;
    m_other   = 1'b0;
    m_map     = 1'b0;
    m_chan    = 2'b11;
  endtask

  task automatic bus_idle();
    addr = '0; din = 4'h0; rw = 1'b1; as_n = 1'b1; ds_n = 1'b1;
    ide_access = 1'b0; ide_enable = 1'b0; z2_state = 2'd0;
  endtask

  // Runs one IDE bus cycle and measures the strobe in edges after DS low.
  task automatic ide_cycle(input logic [23:12] a, input logic rd,
                           output logic [1:0] cs1_obs, output logic [1:0] cs2_obs,
                           output int fall, output int rise,
                           output logic other_low, output logic released);
    logic s;
    fall = 0; rise = 0; other_low = 1'b0;
    addr = a; ide_access = 1'b1; rw = rd; as_n = 1'b0; ds_n = 1'b0;
    #1;
    cs1_obs = idecs1_n;
    cs2_obs = idecs2_n;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      s = rd ? ior_n : iow_n;
      if ((rd ? iow_n : ior_n) == 1'b0) other_low = 1'b1;
      if (fall == 0 && s == 1'b0) fall = k;
      else if (fall != 0 && rise == 0 && s == 1'b1) rise = k;
    end
    ds_n = 1'b1;
    #1;
    released = ior_n & iow_n;
    as_n = 1'b1; ide_access = 1'b0; rw = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one control register cycle; din is scrambled while dtack is held
  // so a repeated update would be visible.
  task automatic reg_cycle(input logic sel, input logic wr, input logic [3:0] d,
                           output logic ra_obs, output logic dt_first,
                           output logic dt_held, output logic dt_after,
                           output logic [3:0] dout_obs);
    addr = mk_addr(1'b0, 1'b1, 1'b0, {1'b0, sel});
    ide_access = 1'b1; rw = !wr; din = d; as_n = 1'b0; ds_n = 1'b0; z2_state = Z2_DATA;
    #1;
    ra_obs = idereg_access;
    @(posedge clk); #1;
    dt_first = dtack;
    dout_obs = dout;
    din = ~d;
    repeat (2) @(posedge clk);
    #1;
    dt_held = dtack;
    as_n = 1'b1; ds_n = 1'b1; z2_state = 2'd0;
    @(posedge clk); #1;
    dt_after = dtack;
    ide_access = 1'b0; rw = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    model_reset();
    #2;
    checks++; if (ide_enabled !== 1'b0) begin errors++; $display("[TB] FAIL reset_ide_enabled: got %b want 0", ide_enabled); end
    checks++; if (dtack !== 1'b0) begin errors++; $display("[TB] FAIL reset_dtack: got %b want 0", dtack); end
    checks++; if (dout !== 4'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h want 0", dout); end
    checks++; if ({ior_n, iow_n} !== 2'b11) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 11", {ior_n, iow_n}); end
    checks++; if ({otherram_en, enable_maprom} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ctrl: got %b want 00", {otherram_en, enable_maprom}); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_enable();
    addr = mk_addr(1'b1, 1'b0, 1'b0, 2'b00); ide_access = 1'b1; rw = 1'b1;
    #1;
    checks++; if (rom_bank !== 2'b01) begin errors++; $display("[TB] FAIL pre_rom_bank: got %b want 01", rom_bank); end
    checks++; if (ide_romen !== 1'b0) begin errors++; $display("[TB] FAIL pre_romen: got %b want 0", ide_romen); end
    rw = 1'b0; ide_enable = 1'b1;
    @(posedge clk); #1;
    m_enabled = 1'b1;
    ide_enable = 1'b0; rw = 1'b1;
    checks++; if (ide_enabled !== 1'b1) begin errors++; $display("[TB] FAIL enable_set: got %b want 1", ide_enabled); end
    checks++; if (rom_bank !== m_bank) begin errors++; $display("[TB] FAIL post_rom_bank: got %b want %b", rom_bank, m_bank); end
    addr = mk_addr(1'b0, 1'b0, 1'b0, 2'b01);
    #1;
    checks++; if (ide_romen !== 1'b1) begin errors++; $display("[TB] FAIL post_romen_drive: got %b want 1", ide_romen); end
    checks++; if (idecs1_n !== 2'b10) begin errors++; $display("[TB] FAIL post_cs1: got %b want 10", idecs1_n); end
    ide_access = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_strobe();
    logic [1:0] c1, c2; int f, r; logic ol, rel;
    ide_cycle(mk_addr(1'b0, 1'b0, 1'b0, 2'b01), 1'b1, c1, c2, f, r, ol, rel);
    checks++; if (c1 !== 2'b10 || c2 !== 2'b11) begin errors++; $display("[TB] FAIL rd_cs: got %b/%b want 10/11", c1, c2); end
    checks++; if (f !== T_SETUP) begin errors++; $display("[TB] FAIL rd_ior_fall: got edge %0d want %0d", f, T_SETUP); end
    checks++; if (r !== 0) begin errors++; $display("[TB] FAIL rd_ior_early_rise: got edge %0d want 0 (none)", r); end
    checks++; if (ol !== 1'b0 || rel !== 1'b1) begin errors++; $display("[TB] FAIL rd_release: iow_low=%b released=%b want 0/1", ol, rel); end
  endtask

  task automatic test_write_strobe();
    logic [1:0] c1, c2; int f, r; logic ol, rel;
    ide_cycle(mk_addr(1'b0, 1'b0, 1'b0, 2'b01), 1'b0, c1, c2, f, r, ol, rel);
    checks++; if (f !== 1) begin errors++; $display("[TB] FAIL wr_iow_fall: got edge %0d want 1", f); end
    checks++; if (r !== T_WRITE + 1) begin errors++; $display("[TB] FAIL wr_iow_rise: got edge %0d want %0d", r, T_WRITE + 1); end
    checks++; if (ol !== 1'b0 || rel !== 1'b1) begin errors++; $display("[TB] FAIL wr_release: ior_low=%b released=%b want 0/1", ol, rel); end
    ide_cycle(mk_addr(1'b0, 1'b0, 1'b0, 2'b10), 1'b0, c1, c2, f, r, ol, rel);
    checks++; if (c1 !== 2'b11 || c2 !== 2'b10) begin errors++; $display("[TB] FAIL wr_cs2: got %b/%b want 11/10", c1, c2); end
    checks++; if (f !== 1 || r !== T_WRITE + 1) begin errors++; $display("[TB] FAIL wr_cs2_timing: got %0d/%0d want 1/%0d", f, r, T_WRITE + 1); end
  endtask

  task automatic test_no_strobe();
    logic [1:0] c1, c2; int f, r; logic ol, rel;
    ide_cycle(mk_addr(1'b1, 1'b0, 1'b0, 2'b01), 1'b1, c1, c2, f, r, ol, rel);
    checks++; if (f !== 0 || ol !== 1'b0) begin errors++; $display("[TB] FAIL rom_no_strobe: got fall %0d other %b want 0/0", f, ol); end
    checks++; if (c1 !== 2'b11 || c2 !== 2'b11) begin errors++; $display("[TB] FAIL rom_cs: got %b/%b want 11/11", c1, c2); end
    ide_cycle(mk_addr(1'b0, 1'b1, 1'b0, 2'b00), 1'b0, c1, c2, f, r, ol, rel);
    checks++; if (f !== 0 || ol !== 1'b0) begin errors++; $display("[TB] FAIL reg_no_strobe: got fall %0d other %b want 0/0", f, ol); end
  endtask

  task automatic test_reg0();
    logic ra, d1, dh, da; logic [3:0] dobs;
    reg_cycle(1'b0, 1'b1, 4'b1011, ra, d1, dh, da, dobs);
    m_bank = 2'b10; m_other = 1'b1; m_map = 1'b1;
    checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL reg0_access: got %b want 1", ra); end
    checks++; if ({d1, dh, da} !== 3'b110) begin errors++; $display("[TB] FAIL reg0_dtack: got %b want 110", {d1, dh, da}); end
    checks++; if (rom_bank !== m_bank) begin errors++; $display("[TB] FAIL reg0_bank: got %b want %b", rom_bank, m_bank); end
    checks++; if ({otherram_en, enable_maprom} !== {m_other, m_map}) begin errors++; $display("[TB] FAIL reg0_ctrl: got %b want %b", {otherram_en, enable_maprom}, {m_other, m_map}); end
    reg_cycle(1'b0, 1'b0, 4'h0, ra, d1, dh, da, dobs);
    checks++; if (dobs !== 4'b1011) begin errors++; $display("[TB] FAIL reg0_read: got %b want 1011", dobs); end
    checks++; if ({d1, dh, da} !== 3'b110) begin errors++; $display("[TB] FAIL reg0_read_dtack: got %b want 110", {d1, dh, da}); end
  endtask

  task automatic test_reg1_channel();
    logic ra, d1, dh, da; logic [3:0] dobs;
    logic [1:0] c1, c2; int f, r; logic ol, rel;
    reg_cycle(1'b1, 1'b1, 4'b0001, ra, d1, dh, da, dobs);
    m_chan = 2'b01;
    reg_cycle(1'b1, 1'b0, 4'h0, ra, d1, dh, da, dobs);
    checks++; if (dobs !== 4'b0001) begin errors++; $display("[TB] FAIL reg1_read: got %b want 0001", dobs); end
    ide_cycle(mk_addr(1'b0, 1'b0, 1'b1, 2'b01), 1'b1, c1, c2, f, r, ol, rel);
    checks++; if (c1 !== 2'b11 || f !== 0) begin errors++; $display("[TB] FAIL ch1_disabled: got cs1 %b fall %0d want 11/0", c1, f); end
    ide_cycle(mk_addr(1'b0, 1'b0, 1'b0, 2'b01), 1'b1, c1, c2, f, r, ol, rel);
    checks++; if (c1 !== 2'b10 || f !== T_SETUP) begin errors++; $display("[TB] FAIL ch0_enabled: got cs1 %b fall %0d want 10/%0d", c1, f, T_SETUP); end
  endtask

  task automatic test_random();
    logic [23:12] a; logic acc;
    logic [1:0] e1, e2, eb; logic er, era;
    logic ra, d1, dh, da, sel; logic [3:0] d, dobs, exp_rd;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = 12'($urandom);
          acc = 1'($urandom);
          addr = a; ide_access = acc; rw = 1'b1;
          #1;
          model_decode(a, acc, e1, e2, er, eb, era);
          checks++; if (idecs1_n !== e1) begin errors++; $display("[TB] FAIL rnd_cs1 a=%h: got %b want %b", a, idecs1_n, e1); end
          checks++; if (idecs2_n !== e2) begin errors++; $display("[TB] FAIL rnd_cs2 a=%h: got %b want %b", a, idecs2_n, e2); end
          checks++; if (ide_romen !== er) begin errors++; $display("[TB] FAIL rnd_romen a=%h: got %b want %b", a, ide_romen, er); end
          checks++; if (rom_bank !== eb) begin errors++; $display("[TB] FAIL rnd_bank a=%h: got %b want %b", a, rom_bank, eb); end
          checks++; if (idereg_access !== era) begin errors++; $display("[TB] FAIL rnd_regacc a=%h: got %b want %b", a, idereg_access, era); end
          ide_access = 1'b0;
          @(posedge clk); #1;
        end
        1: begin
          sel = 1'($urandom);
          d = 4'($urandom);
          reg_cycle(sel, 1'b1, d, ra, d1, dh, da, dobs);
          if (sel) m_chan = d[1:0];
          else begin m_bank = d[3:2]; m_other = d[1]; m_map = d[0]; end
          checks++; if ({d1, dh, da} !== 3'b110) begin errors++; $display("[TB] FAIL rnd_wr_dtack: got %b want 110", {d1, dh, da}); end
          checks++; if ({rom_bank, otherram_en, enable_maprom} !== {m_bank, m_other, m_map}) begin errors++; $display("[TB] FAIL rnd_wr_reg0: got %b want %b", {rom_bank, otherram_en, enable_maprom}, {m_bank, m_other, m_map}); end
        end
        default: begin
          sel = 1'($urandom);
          reg_cycle(sel, 1'b0, 4'($urandom), ra, d1, dh, da, dobs);
          exp_rd = sel ? {2'b00, m_chan} : {m_bank, m_other, m_map};
          checks++; if (dobs !== exp_rd) begin errors++; $display("[TB] FAIL rnd_read sel=%b: got %b want %b", sel, dobs, exp_rd); end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_read();
    logic ra, d1, dh, da; logic [3:0] dobs; logic got_low;
    reg_cycle(1'b1, 1'b1, 4'b0001, ra, d1, dh, da, dobs);
    m_chan = 2'b01;
    reg_cycle(1'b1, 1'b0, 4'h0, ra, d1, dh, da, dobs);
    checks++; if (dobs !== 4'b0001) begin errors++; $display("[TB] FAIL mid_pre_read: got %b want 0001", dobs); end
    addr = mk_addr(1'b0, 1'b0, 1'b0, 2'b01); ide_access = 1'b1; rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
    got_low = 1'b0;
    for (int k = 0; k < 10 && !got_low; k++) begin
      @(posedge clk); #1;
      if (ior_n == 1'b0) got_low = 1'b1;
    end
    checks++; if (got_low !== 1'b1) begin errors++; $display("[TB] FAIL mid_ior_timeout: ior_n never fell, got %b want 0", ior_n); end
    reset_n = 1'b0;
    #1;
    checks++; if ({ior_n, iow_n} !== 2'b11) begin errors++; $display("[TB] FAIL mid_reset_strobes: got %b want 11", {ior_n, iow_n}); end
    checks++; if ({ide_enabled, dtack, dout} !== 6'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got %b want 000000", {ide_enabled, dtack, dout}); end
    checks++; if (idecs1_n !== 2'b11 || rom_bank !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_decode: got %b/%b want 11/00", idecs1_n, rom_bank); end
    bus_idle();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    ide_access = 1'b1; rw = 1'b0; ide_enable = 1'b1;
    @(posedge clk); #1;
    m_enabled = 1'b1;
    ide_enable = 1'b0; rw = 1'b1;
    addr = mk_addr(1'b0, 1'b0, 1'b1, 2'b01);
    #1;
    checks++; if (idecs1_n !== 2'b01) begin errors++; $display("[TB] FAIL mid_chan_restored: got %b want 01", idecs1_n); end
    ide_access = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting ide_multi_ctrl bench");
    test_reset();
    test_enable();
    test_read_strobe();
    test_write_strobe();
    test_no_strobe();
    test_reg0();
    test_reg1_channel();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
